// File: rtl/jump_ctrl_pkg.sv
// Shared constants for the jump controller and flag-mux path: state
// encodings, default widths and the branch-condition rule.
package jump_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam int unsigned DEF_AW = 8;
  localparam int unsigned DEF_CW = 8;

  // A selected flag word means "condition true" when any bit is set.
  function automatic logic cond_true(input logic [3:0] jmp);
    return (jmp != 4'b0000);
  endfunction

endpackage

// File: rtl/jump_ctrl_sat_counter.sv
// Saturating up-counter: counts inc pulses while en is high and sticks at
// all-ones instead of wrapping.
module sat_counter
  import jump_ctrl_pkg::*;
#(
  parameter int unsigned CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  // Increment on enabled inc pulses, hold once the maximum is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en && inc && (cnt != '1)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/jump_ctrl.sv
// Program-counter sequencer: advances pc, redirects on taken branches with
// a one-cycle flush bubble, halts on request, and counts taken branches.
module jump_ctrl
  import jump_ctrl_pkg::*;
#(
  parameter int unsigned    AW       = DEF_AW,
  parameter logic [AW-1:0]  RESET_PC = '0,
  parameter int unsigned    CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          br_valid,
  input  logic          br_uncond,
  input  logic [AW-1:0] br_target,
  input  logic [3:0]    jmp,
  input  logic          halt_req,
  output logic [AW-1:0] pc,
  output logic          pc_valid,
  output logic          flush,
  output logic [CW-1:0] taken_cnt,
  output logic [1:0]    state
);

  state_t st;
  logic   taken;
  logic   taken_inc;

  // Branch resolution; only meaningful while in RUN.
  always_comb begin
    taken     = br_valid & (br_uncond | cond_true(jmp));
    taken_inc = (st == RUN) & ~halt_req & taken;
  end

  assign state = st;

  // Sequencer FSM with registered pc, pc_valid and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= BOOT;
      pc       <= RESET_PC;
      pc_valid <= 1'b0;
      flush    <= 1'b0;
    end else if (en) begin
      case (st)
        BOOT: begin
          st       <= RUN;
          pc       <= RESET_PC;
          pc_valid <= 1'b1;
          flush    <= 1'b0;
        end
        RUN: begin
          if (halt_req) begin
            st       <= HALT;
            pc_valid <= 1'b0;
            flush    <= 1'b0;
          end else if (taken) begin
            st       <= FLUSH;
            pc       <= br_target;
            pc_valid <= 1'b0;
            flush    <= 1'b1;
          end else begin
            pc       <= pc + AW'(1);
            pc_valid <= 1'b1;
            flush    <= 1'b0;
          end
        end
        FLUSH: begin
          st       <= RUN;
          pc_valid <= 1'b1;
          flush    <= 1'b0;
        end
        HALT: begin
          pc_valid <= 1'b0;
          flush    <= 1'b0;
        end
        default: begin
          st       <= BOOT;
          pc       <= RESET_PC;
          pc_valid <= 1'b0;
          flush    <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CW(CW)) u_taken_cnt (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .inc (taken_inc),
    .cnt (taken_cnt)
  );

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed bench for jump_ctrl (CW=2 so saturation is reachable quickly).
module tb_jump_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       br_valid;
  logic       br_uncond;
  logic [7:0] br_target;
  logic [3:0] jmp;
  logic       halt_req;
  logic [7:0] pc;
  logic       pc_valid;
  logic       flush;
  logic [1:0] taken_cnt;
  logic [1:0] state;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [1:0] S_BOOT  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_FLUSH = 2'b10;
  localparam logic [1:0] S_HALT  = 2'b11;

  jump_ctrl #(.AW(8), .RESET_PC(8'h00), .CW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .br_valid  (br_valid),
    .br_uncond (br_uncond),
    .br_target (br_target),
    .jmp       (jmp),
    .halt_req  (halt_req),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .flush     (flush),
    .taken_cnt (taken_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [7:0] p,
                         input logic pv, input logic fl, input logic [1:0] cnt);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".pc"}, 32'(pc), 32'(p));
    chk({tag, ".pc_valid"}, 32'(pc_valid), 32'(pv));
    chk({tag, ".flush"}, 32'(flush), 32'(fl));
    chk({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(cnt));
  endtask

  task automatic idle_inputs();
    br_valid  = 1'b0;
    br_uncond = 1'b0;
    br_target = 8'h00;
    jmp       = 4'b0000;
    halt_req  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    idle_inputs();

    // Reset state, then one BOOT cycle after release
    #2;
    chk_all("reset", S_BOOT, 8'h00, 1'b0, 1'b0, 2'd0);
    #10;
    rst = 1'b0;
    #1;
    chk_all("boot", S_BOOT, 8'h00, 1'b0, 1'b0, 2'd0);

    // Free run 0..5
    tick(); chk_all("run0", S_RUN, 8'h00, 1'b1, 1'b0, 2'd0);
    tick(); chk_all("run1", S_RUN, 8'h01, 1'b1, 1'b0, 2'd0);
    tick(); chk_all("run2", S_RUN, 8'h02, 1'b1, 1'b0, 2'd0);
    tick(); chk_all("run3", S_RUN, 8'h03, 1'b1, 1'b0, 2'd0);
    tick(); tick();
    chk("run5.pc", 32'(pc), 32'h05);

    // Conditional taken at pc=5 to 0x40
    br_valid = 1'b1; jmp = 4'b0010; br_target = 8'h40;
    tick(); chk_all("ctaken.n1", S_FLUSH, 8'h40, 1'b0, 1'b1, 2'd1);
    // Killed slot: branch and halt in FLUSH are ignored
    br_valid = 1'b1; jmp = 4'b1111; br_target = 8'h99; halt_req = 1'b1;
    tick(); chk_all("ctaken.n2", S_RUN, 8'h40, 1'b1, 1'b0, 2'd1);
    idle_inputs();
    tick(); chk_all("ctaken.n3", S_RUN, 8'h41, 1'b1, 1'b0, 2'd1);

    // Conditional not taken -> fall through
    br_valid = 1'b1; jmp = 4'b0000; br_target = 8'h80;
    tick(); chk_all("ntaken", S_RUN, 8'h42, 1'b1, 1'b0, 2'd1);

    // Unconditional taken with jmp=0 to 0xFE
    br_valid = 1'b1; br_uncond = 1'b1; br_target = 8'hFE;
    tick(); chk_all("utaken.n1", S_FLUSH, 8'hFE, 1'b0, 1'b1, 2'd2);
    idle_inputs();
    tick(); chk_all("utaken.n2", S_RUN, 8'hFE, 1'b1, 1'b0, 2'd2);

    // Stall and wrap: en 1,0,0,1,1
    en = 1'b1; tick(); chk("wrap.a", 32'(pc), 32'hFF);
    en = 1'b0; tick(); chk("wrap.b", 32'(pc), 32'hFF);
    en = 1'b0; tick(); chk("wrap.c", 32'(pc), 32'hFF);
    en = 1'b1; tick(); chk("wrap.d", 32'(pc), 32'h00);
    en = 1'b1; tick(); chk_all("wrap.e", S_RUN, 8'h01, 1'b1, 1'b0, 2'd2);

    // Stall during FLUSH keeps flush asserted
    br_valid = 1'b1; jmp = 4'b0001; br_target = 8'h10;
    tick(); chk_all("fstall.n1", S_FLUSH, 8'h10, 1'b0, 1'b1, 2'd3);
    idle_inputs();
    en = 1'b0;
    tick(); chk_all("fstall.hold1", S_FLUSH, 8'h10, 1'b0, 1'b1, 2'd3);
    tick(); chk_all("fstall.hold2", S_FLUSH, 8'h10, 1'b0, 1'b1, 2'd3);
    en = 1'b1;
    tick(); chk_all("fstall.rel", S_RUN, 8'h10, 1'b1, 1'b0, 2'd3);

    // Fourth taken branch: counter saturated
    br_valid = 1'b1; jmp = 4'b1000; br_target = 8'h20;
    tick(); chk_all("sat4", S_FLUSH, 8'h20, 1'b0, 1'b1, 2'd3);
    idle_inputs();
    tick(); chk_all("sat4.run", S_RUN, 8'h20, 1'b1, 1'b0, 2'd3);

    // Fifth taken branch, tight loop (target == pc)
    br_valid = 1'b1; br_uncond = 1'b1; br_target = 8'h20;
    tick(); chk_all("sat5", S_FLUSH, 8'h20, 1'b0, 1'b1, 2'd3);
    idle_inputs();

    // Async reset between edges while in FLUSH
    #2;
    rst = 1'b1;
    #1;
    chk_all("areset", S_BOOT, 8'h00, 1'b0, 1'b0, 2'd0);
    #2;
    rst = 1'b0;
    tick(); chk_all("post.run0", S_RUN, 8'h00, 1'b1, 1'b0, 2'd0);
    tick(); chk("post.run1", 32'(pc), 32'h01);

    // Halt beats a same-cycle taken branch
    halt_req = 1'b1; br_valid = 1'b1; br_uncond = 1'b1; br_target = 8'h55;
    tick(); chk_all("halt", S_HALT, 8'h01, 1'b0, 1'b0, 2'd0);
    halt_req = 1'b0; jmp = 4'b0100;
    tick(); chk_all("halt.hold", S_HALT, 8'h01, 1'b0, 1'b0, 2'd0);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
